// File: rtl/seg_scan_decoder.sv
// Seven-segment scan bus readback: synchronize, settle-filter and
// decode multiplexed digits into complete frames.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_an,
  input  logic [6:0]  i_seg,
  output logic [31:0] o_digits,
  output logic [7:0]  o_blank,
  output logic        o_frame_valid,
  output logic        o_err,
  output logic        o_stale
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0][14:0] sync_q;
  logic [14:0]   sample;
  logic [14:0]   prev_q;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [7:0]    sblank_q, sblank_d;
  logic [7:0]    seen_q, seen_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   digits_q;
  logic [7:0]    blank_q;
  logic          fv_q, err_q, err_d;

  logic          same, accept, frame;
  logic [7:0]    anl;
  logic [6:0]    gly;
  logic          a_idle, a_one;
  logic [2:0]    idx;
  logic [3:0]    nib;
  logic          g_ok, g_blank, cap;

  assign sample = sync_q[SYNC_STAGES-1];

  always_comb begin
    same    = (sample == prev_q);
    cnt_d   = cnt_q;
    armed_d = armed_q;
    accept  = armed_q && (cnt_q == SETTLE);
    if (same) begin
      if (cnt_q != SETTLE) cnt_d = cnt_q + 1'b1;
      armed_d = armed_q && !accept;
    end else begin
      cnt_d   = SW'(1);
      armed_d = 1'b1;
    end
  end

  // prev_q holds the value whose run length is cnt_q
  always_comb begin
    anl    = ~prev_q[14:7];
    gly    = ~prev_q[6:0];
    a_idle = (anl == 8'h00);
    a_one  = !a_idle && ((anl & (anl - 8'd1)) == 8'h00);
    idx    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (anl[i]) idx = 3'(i);
    end
  end

  always_comb begin
    nib     = 4'h0;
    g_ok    = 1'b1;
    g_blank = 1'b0;
    case (gly)
      7'h3F:   nib = 4'h0;
      7'h06:   nib = 4'h1;
      7'h5B:   nib = 4'h2;
      7'h4F:   nib = 4'h3;
      7'h66:   nib = 4'h4;
      7'h6D:   nib = 4'h5;
      7'h7D:   nib = 4'h6;
      7'h07:   nib = 4'h7;
      7'h7F:   nib = 4'h8;
      7'h6F:   nib = 4'h9;
      7'h77:   nib = 4'hA;
      7'h7C:   nib = 4'hB;
      7'h39:   nib = 4'hC;
      7'h5E:   nib = 4'hD;
      7'h79:   nib = 4'hE;
      7'h71:   nib = 4'hF;
      7'h00:   g_blank = 1'b1;
      default: g_ok = 1'b0;
    endcase
  end

  always_comb begin
    cap      = accept && a_one && g_ok;
    err_d    = accept && !a_idle && !(a_one && g_ok);
    shadow_d = shadow_q;
    sblank_d = sblank_q;
    seen_d   = seen_q;
    if (cap) begin
      shadow_d[{idx, 2'b00} +: 4] = nib;
      sblank_d[idx] = g_blank;
      seen_d[idx]   = 1'b1;
    end
    frame = (seen_d == 8'hFF);
    tmo_d = tmo_q;
    if (accept && a_one)   tmo_d = '0;
    else if (tmo_q != TMAX) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q   <= '1;
      prev_q   <= '1;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      shadow_q <= '0;
      sblank_q <= 8'hFF;
      seen_q   <= '0;
      tmo_q    <= '0;
      digits_q <= '0;
      blank_q  <= 8'hFF;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], {i_an, i_seg}};
      prev_q   <= sample;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      shadow_q <= shadow_d;
      sblank_q <= sblank_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      fv_q     <= frame;
      if (frame) begin
        seen_q   <= '0;
        digits_q <= shadow_d;
        blank_q  <= sblank_d;
      end else begin
        seen_q <= seen_d;
      end
    end
  end

  assign o_digits      = digits_q;
  assign o_blank       = blank_q;
  assign o_frame_valid = fv_q;
  assign o_err         = err_q;
  assign o_stale       = (tmo_q == TMAX);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans, glitches, illegal
// samples, timeout and mid-frame reset.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  an = 8'hFF;
  logic [6:0]  seg = 7'h7F;
  logic [31:0] digits;
  logic [7:0]  blank;
  logic        fv, err, stale;

  int checks = 0;
  int errors = 0;
  int fv_n = 0;
  int err_n = 0;
  int both_n = 0;
  logic [31:0] last_dig = '0;
  logic [7:0]  last_blank = '0;

  logic [6:0] gly [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  seg_scan_decoder #(
    .SETTLE_CYCLES(16),
    .TIMEOUT_CYCLES(100),
    .SYNC_STAGES(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .i_an(an),
    .i_seg(seg),
    .o_digits(digits),
    .o_blank(blank),
    .o_frame_valid(fv),
    .o_err(err),
    .o_stale(stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fv) begin
      fv_n++;
      last_dig   = digits;
      last_blank = blank;
    end
    if (err) err_n++;
    if (fv && err) both_n++;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [6:0] s,
                       input int cyc);
    @(negedge clk);
    an  = a;
    seg = s;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic show(input int d, input int v);
    drive(~(8'h01 << d), ~gly[v], 20);
  endtask

  task automatic glitch();
    drive(8'hFC, 7'($urandom_range(0, 127)), 5);
  endtask

  int f0, e0;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_digits", digits, 32'h0);
    check("rst_blank", blank, 32'hFF);
    check("rst_fv", fv_n, 0);
    check("rst_err", err_n, 0);
    check("rst_stale", stale, 0);
    repeat (110) @(negedge clk);
    check("stale_set", stale, 1);

    for (int d = 0; d < 8; d++) show(d, d);
    drive(8'hFF, 7'h7F, 5);
    check("scan1_fv", fv_n, 1);
    check("scan1_dig", last_dig, 32'h76543210);
    check("scan1_blank", last_blank, 32'h0);
    check("scan1_err", err_n, 0);
    check("scan1_stale", stale, 0);

    for (int d = 0; d < 8; d++) begin
      glitch();
      show(d, d);
    end
    drive(8'hFF, 7'h7F, 5);
    check("glitch_fv", fv_n, 2);
    check("glitch_dig", last_dig, 32'h76543210);
    check("glitch_err", err_n, 0);

    f0 = fv_n;
    drive(8'hFC, 7'h40, 20);
    drive(8'hFF, 7'h7F, 5);
    check("multi_err", err_n, 1);
    check("multi_fv", fv_n, f0);
    drive(8'hF7, 7'h00, 20);
    for (int d = 0; d < 8; d++) if (d != 3) show(d, d);
    drive(8'hFF, 7'h7F, 5);
    check("g8_fv", fv_n, f0 + 1);
    check("g8_dig", last_dig, 32'h76548210);
    check("g8_err", err_n, 1);

    f0 = fv_n;
    e0 = err_n;
    for (int d = 0; d < 5; d++) show(d, d);
    drive(8'hDF, 7'h7F, 20);
    show(7, 7);
    drive(8'hBF, 7'h7E, 20);
    drive(8'hFF, 7'h7F, 5);
    check("ill_err", err_n, e0 + 1);
    check("ill_nofv", fv_n, f0);
    show(6, 6);
    check("ill_fv", fv_n, f0 + 1);
    check("blank_dig", last_dig, 32'h76043210);
    check("blank_msk", last_blank, 32'h20);

    for (int d = 0; d < 4; d++) show(d, 10 + d);
    @(negedge clk);
    rst_n = 1'b0;
    an    = 8'hFF;
    seg   = 7'h7F;
    repeat (3) @(negedge clk);
    check("mid_rst_dig", digits, 32'h0);
    check("mid_rst_blank", blank, 32'hFF);
    rst_n = 1'b1;
    f0 = fv_n;
    for (int d = 0; d < 7; d++) show(d, 8 + d);
    check("post_rst_nofv", fv_n, f0);
    @(negedge clk);
    an  = 8'h7F;
    seg = ~gly[15];
    repeat (16) @(negedge clk);
    check("no_early_fv", fv_n, f0);
    repeat (4) @(negedge clk);
    check("post_rst_fv", fv_n, f0 + 1);
    check("post_rst_dig", last_dig, 32'hFEDCBA98);
    check("post_rst_blank", last_blank, 32'h0);
    drive(8'hFF, 7'h7F, 5);
    check("fv_err_overlap", both_n, 0);
    check("err_total", err_n, e0 + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
